// File: rtl/timer_master.sv
// -----------------------------------------------------------------------------
// timer_master
// Bus initiator for the 32-bit memory-mapped timer peripheral. On a host start
// it writes the period, enables the timer, then polls the control register for
// the TMR flag. Every detected expiry becomes a one-cycle tick and increments
// tick_count. A host stop disables the timer and returns to IDLE.
//
// Optional build macro: TIMER_MASTER_OVERRUN_EN
//   When defined, the toggle bit of the control register is tracked and a
//   sticky overrun flag is raised when an expiry was missed between polls.
//   When undefined, overrun is tied low.
// -----------------------------------------------------------------------------
module timer_master #(
  parameter int POLL_GAP = 0,   // idle cycles between control-register polls
  parameter int CNT_W    = 16   // width of tick_count
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active-low
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      period_in,
  output logic             busy,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic             overrun,
  output logic             bus_wren,
  output logic             bus_rden,
  output logic [1:0]       bus_addr,
  output logic [31:0]      bus_wdata,
  input  logic [31:0]      bus_rdata
);

  // Peripheral register map
  localparam logic [1:0] ADDR_PERIOD = 2'b01;
  localparam logic [1:0] ADDR_CTRL   = 2'b10;

  // Control word: bit0 enable, bit1 TMR, bit2 toggle
  localparam logic [31:0] CTRL_ENABLE  = 32'h0000_0001;
  localparam logic [31:0] CTRL_DISABLE = 32'h0000_0000;

  // Gap counter holds POLL_GAP-1 down to 0
  localparam int             GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (POLL_GAP > 0) ? GAP_W'(POLL_GAP - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_PER,
    S_WR_CTL,
    S_GAP,
    S_POLL,
    S_WR_STOP
  } state_t;

  // State after a poll or after enabling: straight back to POLL, or via GAP
  localparam state_t S_AFTER_POLL = (POLL_GAP == 0) ? S_POLL : S_GAP;

  state_t             r_state;
  state_t             w_next_state;
  logic [31:0]        r_period;
  logic [31:0]        w_period_d;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_tick;
  logic [CNT_W-1:0]   r_tick_count;
  logic               r_bus_wren;
  logic               r_bus_rden;
  logic [1:0]         r_bus_addr;
  logic [31:0]        r_bus_wdata;
  logic               w_wren;
  logic               w_rden;
  logic [1:0]         w_addr;
  logic [31:0]        w_wdata;
  logic               w_accept;
  logic               w_tmr_seen;
  logic               w_unused_rdata;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_tmr_seen = (r_state == S_POLL) && bus_rdata[1];

  // Value period_q will hold after this edge; the period write uses it directly
  assign w_period_d = w_accept ? period_in : r_period;

  // State register
  // NOTE: every flop in this file is updated with <= so all registers sample
  // the same pre-edge values; blocking assignments here would create order-
  // dependent races between always_ff blocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  // NOTE: the default assignment at the top of each always_comb keeps every
  // path driven, so no latch is inferred for unlisted cases.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next_state = S_WR_PER;
      S_WR_PER:  w_next_state = S_WR_CTL;
      S_WR_CTL:  w_next_state = S_AFTER_POLL;
      S_GAP: begin
        if (stop)                 w_next_state = S_WR_STOP;
        else if (r_gap_cnt == '0) w_next_state = S_POLL;
      end
      S_POLL:    w_next_state = stop ? S_WR_STOP : S_AFTER_POLL;
      S_WR_STOP: w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Bus strobes for the upcoming state; registered below so the pins are flops
  always_comb begin
    w_wren  = 1'b0;
    w_rden  = 1'b0;
    w_addr  = 2'b00;
    w_wdata = 32'h0;
    case (w_next_state)
      S_WR_PER: begin
        w_wren  = 1'b1;
        w_addr  = ADDR_PERIOD;
        w_wdata = w_period_d;
      end
      S_WR_CTL: begin
        w_wren  = 1'b1;
        w_addr  = ADDR_CTRL;
        w_wdata = CTRL_ENABLE;
      end
      S_POLL: begin
        w_rden  = 1'b1;
        w_addr  = ADDR_CTRL;
      end
      S_WR_STOP: begin
        w_wren  = 1'b1;
        w_addr  = ADDR_CTRL;
        w_wdata = CTRL_DISABLE;
      end
      default: ;
    endcase
  end

  // Registered bus outputs; reset drops any strobe immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bus_wren  <= 1'b0;
      r_bus_rden  <= 1'b0;
      r_bus_addr  <= 2'b00;
      r_bus_wdata <= 32'h0;
    end else begin
      r_bus_wren  <= w_wren;
      r_bus_rden  <= w_rden;
      r_bus_addr  <= w_addr;
      r_bus_wdata <= w_wdata;
    end
  end

  // Period capture on an accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_period <= 32'h0;
    end else begin
      r_period <= w_period_d;
    end
  end

  // Poll spacing: load on entry to GAP, count down while waiting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gap_cnt <= '0;
    end else if ((w_next_state == S_GAP) && (r_state != S_GAP)) begin
      r_gap_cnt <= GAP_LOAD;
    end else if ((r_state == S_GAP) && (r_gap_cnt != '0)) begin
      r_gap_cnt <= r_gap_cnt - GAP_W'(1);
    end
  end

  // Tick pulse and wrapping event counter, cleared by each accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick       <= 1'b0;
      r_tick_count <= '0;
    end else begin
      r_tick <= w_tmr_seen;
      if (w_accept) begin
        r_tick_count <= '0;
      end else if (w_tmr_seen) begin
        r_tick_count <= r_tick_count + CNT_W'(1);
      end
    end
  end

`ifdef TIMER_MASTER_OVERRUN_EN
  logic r_last_toggle;
  logic r_overrun;

  // An expiry whose toggle parity matches the last one seen means an even
  // number of expiries happened since, so at least one was missed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_toggle <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_overrun <= 1'b0;
      end else if (w_tmr_seen && (bus_rdata[2] == r_last_toggle)) begin
        r_overrun <= 1'b1;
      end
      if (r_state == S_WR_CTL) begin
        r_last_toggle <= 1'b0;
      end else if (w_tmr_seen) begin
        r_last_toggle <= bus_rdata[2];
      end
    end
  end

  assign overrun        = r_overrun;
  assign w_unused_rdata = ^{bus_rdata[31:3], bus_rdata[0]};
`else
  assign overrun        = 1'b0;
  assign w_unused_rdata = ^{bus_rdata[31:2], bus_rdata[0]};
`endif

  assign busy       = (r_state != S_IDLE);
  assign tick       = r_tick;
  assign tick_count = r_tick_count;
  assign bus_wren   = r_bus_wren;
  assign bus_rden   = r_bus_rden;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;

endmodule

// File: tb/tb_timer_master.sv
// -----------------------------------------------------------------------------
// tb_timer_master
// Two timer_master instances (POLL_GAP=0 and POLL_GAP=3), each attached to a
// behavioural model of the timer peripheral. Expected bus operations and ticks
// are queued when the host stimulus or a TMR poll is observed and compared
// when the DUT produces them. Build with +define+TIMER_MASTER_OVERRUN_EN to
// also expect the overrun flag.
// -----------------------------------------------------------------------------
module tb_timer_master;

  localparam int CNT_W = 16;
  localparam int NI    = 2;
  localparam int GAP_A = 0;
  localparam int GAP_B = 3;

  typedef struct packed {
    logic        wren;
    logic        rden;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } bus_op_t;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             ovr;
  } tick_exp_t;

  typedef enum int {M_IDLE, M_PROG, M_POLL} mode_t;

  localparam bus_op_t OP_IDLE = '{wren: 1'b0, rden: 1'b0, addr: 2'b00, wdata: 32'h0};
  localparam bus_op_t OP_POLL = '{wren: 1'b0, rden: 1'b1, addr: 2'b10, wdata: 32'h0};

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start      [NI];
  logic             stop       [NI];
  logic [31:0]      period_in  [NI];
  logic             busy       [NI];
  logic             tick       [NI];
  logic [CNT_W-1:0] tick_count [NI];
  logic             overrun    [NI];
  logic             bus_wren   [NI];
  logic             bus_rden   [NI];
  logic [1:0]       bus_addr   [NI];
  logic [31:0]      bus_wdata  [NI];
  logic [31:0]      bus_rdata  [NI];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int G = (g == 0) ? GAP_A : GAP_B;

    timer_master #(.POLL_GAP(G), .CNT_W(CNT_W)) u_dut (
      .clk        (clk),
      .reset      (rst_n),
      .start      (start[g]),
      .stop       (stop[g]),
      .period_in  (period_in[g]),
      .busy       (busy[g]),
      .tick       (tick[g]),
      .tick_count (tick_count[g]),
      .overrun    (overrun[g]),
      .bus_wren   (bus_wren[g]),
      .bus_rden   (bus_rden[g]),
      .bus_addr   (bus_addr[g]),
      .bus_wdata  (bus_wdata[g]),
      .bus_rdata  (bus_rdata[g])
    );

    // ---------------- timer peripheral model ----------------
    logic [31:0] p_timer;
    logic [31:0] p_period;
    logic        p_en;
    logic        p_tmr;
    logic        p_tog;
    int          p_nexp;    // expiries since TMR was last cleared
    logic        p_expire;
    logic        p_rdclr;

    assign p_expire = p_en && (p_timer == p_period);
    assign p_rdclr  = bus_rden[g] && (bus_addr[g] == 2'b10);

    assign bus_rdata[g] = (bus_addr[g] == 2'b00) ? p_timer :
                          (bus_addr[g] == 2'b01) ? p_period :
                          (bus_addr[g] == 2'b10) ? {29'h0, p_tog, p_tmr, p_en} : 32'h0;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p_timer  <= 32'h0;
        p_period <= 32'h0;
        p_en     <= 1'b0;
        p_tmr    <= 1'b0;
        p_tog    <= 1'b0;
        p_nexp   <= 0;
      end else begin
        if (bus_wren[g] && bus_addr[g] == 2'b01) p_period <= bus_wdata[g];
        if (bus_wren[g] && bus_addr[g] == 2'b10) begin
          p_en    <= bus_wdata[g][0];
          p_tmr   <= bus_wdata[g][1];
          p_tog   <= bus_wdata[g][2];
          p_timer <= 32'h0;
          p_nexp  <= 0;
        end else begin
          if (p_expire) begin
            p_timer <= 32'h0;
            p_tmr   <= 1'b1;
            p_tog   <= ~p_tog;
          end else begin
            if (p_en) p_timer <= p_timer + 32'h1;
            if (p_rdclr) p_tmr <= 1'b0;
          end
          if (p_rdclr) p_nexp <= p_expire ? 1 : 0;
          else         p_nexp <= p_nexp + (p_expire ? 1 : 0);
        end
      end
    end

    // ---------------- scoreboard / monitor ----------------
    mode_t            mode;
    mode_t            after_mode;
    bus_op_t          ops[$];
    tick_exp_t        ticks[$];
    logic             tick_due;
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_ovr;
    int               poll_wait;
    int               n_ticks;
    logic             wrap_seen;

    initial begin
      bus_op_t   act_op;
      bus_op_t   exp_op;
      tick_exp_t e;
      string     pre;
      pre        = $sformatf("g%0d_", g);
      mode       = M_IDLE;
      after_mode = M_IDLE;
      tick_due   = 1'b0;
      exp_cnt    = '0;
      exp_ovr    = 1'b0;
      poll_wait  = 0;
      n_ticks    = 0;
      wrap_seen  = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          mode     = M_IDLE;
          ops.delete();
          ticks.delete();
          tick_due = 1'b0;
          exp_cnt  = '0;
          exp_ovr  = 1'b0;
        end else begin
          act_op = '{wren: bus_wren[g], rden: bus_rden[g], addr: bus_addr[g], wdata: bus_wdata[g]};

          // tick pulse
          if (tick_due) begin
            check({pre, "tick_queue"}, 64'(ticks.size() > 0), 64'd1);
            if (ticks.size() > 0) begin
              e = ticks.pop_front();
              check({pre, "tick"}, 64'(tick[g]), 64'd1);
              check({pre, "tick_count_at_tick"}, 64'(tick_count[g]), 64'(e.cnt));
              check({pre, "overrun_at_tick"}, 64'(overrun[g]), 64'(e.ovr));
              n_ticks++;
              if (e.cnt == '0) wrap_seen = 1'b1;
            end
            tick_due = 1'b0;
          end else begin
            check({pre, "tick_idle"}, 64'(tick[g]), 64'd0);
          end
          check({pre, "tick_count"}, 64'(tick_count[g]), 64'(exp_cnt));
          check({pre, "overrun"}, 64'(overrun[g]), 64'(exp_ovr));

          // bus activity
          case (mode)
            M_IDLE: begin
              check({pre, "busy_idle"}, 64'(busy[g]), 64'd0);
              check({pre, "bus_idle"}, 64'(act_op), 64'(OP_IDLE));
            end
            M_PROG: begin
              check({pre, "busy_prog"}, 64'(busy[g]), 64'd1);
              exp_op = (ops.size() > 0) ? ops.pop_front() : OP_IDLE;
              check({pre, "bus_write"}, 64'(act_op), 64'(exp_op));
              if (ops.size() == 0) mode = after_mode;
            end
            default: begin
              check({pre, "busy_poll"}, 64'(busy[g]), 64'd1);
              if (poll_wait == 0) begin
                exp_op    = OP_POLL;
                poll_wait = G;
              end else begin
                exp_op    = OP_IDLE;
                poll_wait = poll_wait - 1;
              end
              check({pre, "bus_poll"}, 64'(act_op), 64'(exp_op));
            end
          endcase

          // expectations produced by this cycle's poll result and host inputs
          if (bus_rden[g] && bus_addr[g] == 2'b10 && bus_rdata[g][1]) begin
            exp_cnt = exp_cnt + CNT_W'(1);
`ifdef TIMER_MASTER_OVERRUN_EN
            if (p_nexp % 2 == 0) exp_ovr = 1'b1;
`endif
            ticks.push_back('{cnt: exp_cnt, ovr: exp_ovr});
            tick_due = 1'b1;
          end
          if (mode == M_IDLE && start[g]) begin
            exp_cnt    = '0;
            exp_ovr    = 1'b0;
            ops.push_back('{wren: 1'b1, rden: 1'b0, addr: 2'b01, wdata: period_in[g]});
            ops.push_back('{wren: 1'b1, rden: 1'b0, addr: 2'b10, wdata: 32'h1});
            mode       = M_PROG;
            after_mode = M_POLL;
            poll_wait  = G;
          end else if (mode == M_POLL && stop[g]) begin
            ops.push_back('{wren: 1'b1, rden: 1'b0, addr: 2'b10, wdata: 32'h0});
            mode       = M_PROG;
            after_mode = M_IDLE;
          end
        end
      end
    end
  end

  // ---------------- host stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] pa, input logic [31:0] pb);
    period_in[0] = pa;
    period_in[1] = pb;
    start[0]     = 1'b1;
    start[1]     = 1'b1;
    step(1);
    start[0]     = 1'b0;
    start[1]     = 1'b0;
  endtask

  task automatic pulse_stop();
    stop[0] = 1'b1;
    stop[1] = 1'b1;
    step(1);
    stop[0] = 1'b0;
    stop[1] = 1'b0;
  endtask

  initial begin
    logic found;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start[i]     = 1'b0;
      stop[i]      = 1'b0;
      period_in[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step(3);

    // program, enable and poll: period 4 on gap 0, period 15 on gap 3
    pulse_start(32'h4, 32'hF);
    step(30);

    // start while busy is ignored, including its period value
    pulse_start(32'h99, 32'h99);
    step(40);

    // stop on the same cycle a gap-0 poll returns TMR
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus_rden[0] && bus_rdata[0][1]) found = 1'b1;
      else step(1);
    end
    check("stop_sync_found", 64'(found), 64'd1);
    pulse_stop();
    step(6);

    // stop while idle is ignored
    pulse_stop();
    step(6);

    // period 0: gap 0 ticks every poll (long enough to wrap tick_count),
    // gap 3 misses expiries between polls
    pulse_start(32'h0, 32'h0);
    step(65545);
    pulse_stop();
    step(6);

    // reset asserted mid-poll clears every output at once
    pulse_start(32'h4, 32'h4);
    step(10);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_busy%0d", i),      64'(busy[i]),       64'd0);
      check($sformatf("rst_tick%0d", i),      64'(tick[i]),       64'd0);
      check($sformatf("rst_count%0d", i),     64'(tick_count[i]), 64'd0);
      check($sformatf("rst_overrun%0d", i),   64'(overrun[i]),    64'd0);
      check($sformatf("rst_wren%0d", i),      64'(bus_wren[i]),   64'd0);
      check($sformatf("rst_rden%0d", i),      64'(bus_rden[i]),   64'd0);
      check($sformatf("rst_addr%0d", i),      64'(bus_addr[i]),   64'd0);
      check($sformatf("rst_wdata%0d", i),     64'(bus_wdata[i]),  64'd0);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(10);

    check("ticks_seen_g0", 64'(g_inst[0].n_ticks > 65536), 64'd1);
    check("ticks_seen_g1", 64'(g_inst[1].n_ticks > 3), 64'd1);
    check("wrap_seen_g0", 64'(g_inst[0].wrap_seen), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
